yildiz_mem_dump: RTL

Memory readback engine for the YildizCPU16 debug/load port. It is the reader counterpart to the program-load writer path (`we_in`/`sel_in`/`adr_in`/`data_in`). On `start` it reads a contiguous block of words through the same port with write-enable held low. It streams each word, tagged with its address, out over a valid/ready interface and reports a 16-bit running checksum. It sits between the CPU's external memory port and bench or host-side consumers, such as a UART bridge or a scoreboard.

---
 rtl/yildiz_pkg.sv | 16 +
 rtl/yildiz_mem_dump.sv | 131 +++++++++++++
 2 files changed

// File: rtl/yildiz_pkg.sv
// Shared types and sizes for the YildizCPU16 memory dump engine.
// Imported by the dump FSM.
package yildiz_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    DONE
  } dump_state_t;

endpackage

// File: rtl/yildiz_mem_dump.sv
// Memory readback engine: reads a block through the CPU load port,
// streams address-tagged words over valid/ready, sums them mod 2^16.
module yildiz_mem_dump #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_adr
);

  import yildiz_pkg::*;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [ADDR_W-1:0] oadr_q, oadr_d;
  logic [ADDR_W-1:0] madr_q, madr_d;
  logic              busy_q, done_q, sel_q, valid_q;

  // Next-state, datapath updates and the address presented to memory.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    sum_d   = sum_q;
    odata_d = odata_q;
    oadr_d  = oadr_q;
    madr_d  = madr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_adr;
          rem_d   = count;
          sum_d   = '0;
          state_d = (count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = 2'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == 2'd0) begin
          odata_d = mem_rdata;
          oadr_d  = addr_q;
          sum_d   = sum_q + mem_rdata;
          state_d = OUT;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = (rem_q == (ADDR_W+1)'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == ISSUE) begin
      madr_d = addr_d;
    end
  end

  // State, datapath and registered outputs; all clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      sum_q   <= '0;
      odata_q <= '0;
      oadr_q  <= '0;
      madr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      sum_q   <= sum_d;
      odata_q <= odata_d;
      oadr_q  <= oadr_d;
      madr_q  <= madr_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      sel_q   <= (state_d == ISSUE) || (state_d == WAIT);
      valid_q <= (state_d == OUT);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = sum_q;
  assign mem_sel   = sel_q;
  assign mem_we    = 1'b0;
  assign mem_adr   = madr_q;
  assign out_valid = valid_q;
  assign out_data  = odata_q;
  assign out_adr   = oadr_q;

endmodule
